// File: rtl/butterfly_pkg.sv
// Shared constants, FSM encoding and butterfly pairing helpers for the
// sequential radix-2 butterfly engine.
package butterfly_pkg;

  localparam int DATA_W = 15;
  localparam int NPTS   = 8;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_UNLOAD  = 2'd2
  } bf_state_e;

  // Low index of pair k in stage s: lo = (k/h)*2h + (k mod h), with h = 4 >> s.
  function automatic logic [2:0] bf_lo_idx(input logic [1:0] stage, input logic [1:0] pair);
    logic [2:0] idx;
    case (stage)
      2'd0:    idx = {1'b0, pair};
      2'd1:    idx = {pair[1], 1'b0, pair[0]};
      2'd2:    idx = {pair, 1'b0};
      default: idx = 3'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [2:0] bf_hi_idx(input logic [1:0] stage, input logic [1:0] pair);
    return bf_lo_idx(stage, pair) + (3'd4 >> stage);
  endfunction

endpackage

// File: rtl/butterfly2.sv
// Two-point butterfly: sum and scaled difference, both wrapping modulo 2^DATA_W.
module butterfly2
  import butterfly_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] ao_o,
  output logic [DATA_W-1:0] bo_o
);

  logic [DATA_W-1:0] diff_s;

  assign ao_o   = a_i + b_i;
  assign diff_s = a_i - b_i;
  assign bo_o   = {diff_s[DATA_W-5:0], 4'b0000};

endmodule

// File: rtl/butterfly_seq.sv
// Block engine: loads 8 samples, runs S in-place butterfly stages one pair
// per cycle through a shared butterfly2, then streams the block out.
module butterfly_seq
  import butterfly_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        cfg_stages,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  bf_state_e         state_q, state_d;
  logic [2:0]        ld_idx_q, ld_idx_d;
  logic [2:0]        ul_idx_q, ul_idx_d;
  logic [1:0]        stage_q, stage_d;
  logic [1:0]        pair_q, pair_d;
  logic [1:0]        s_q, s_d;
  logic [DATA_W-1:0] buf_q [NPTS];

  logic              ld_we_s, bf_we_s;
  logic [2:0]        lo_idx_s, hi_idx_s;
  logic [DATA_W-1:0] ao_s, bo_s;

  assign lo_idx_s = bf_lo_idx(stage_q, pair_q);
  assign hi_idx_s = bf_hi_idx(stage_q, pair_q);

  butterfly2 u_bf (
    .a_i  (buf_q[lo_idx_s]),
    .b_i  (buf_q[hi_idx_s]),
    .ao_o (ao_s),
    .bo_o (bo_s)
  );

  // Next-state, counters and buffer write enables
  always_comb begin
    state_d  = state_q;
    ld_idx_d = ld_idx_q;
    ul_idx_d = ul_idx_q;
    stage_d  = stage_q;
    pair_d   = pair_q;
    s_d      = s_q;
    ld_we_s  = 1'b0;
    bf_we_s  = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          ld_we_s  = 1'b1;
          ld_idx_d = ld_idx_q + 3'd1;
          if (ld_idx_q == 3'd0) s_d = cfg_stages;
          else                  s_d = s_q;
          if (ld_idx_q == 3'd7) state_d = (s_q != 2'd0) ? ST_COMPUTE : ST_UNLOAD;
          else                  state_d = ST_LOAD;
        end else begin
          ld_we_s = 1'b0;
        end
      end
      ST_COMPUTE: begin
        bf_we_s = 1'b1;
        if (pair_q == 2'd3) begin
          pair_d = 2'd0;
          // Last pair of the last requested stage hands over to unload
          if (stage_q == s_q - 2'd1) begin
            stage_d = 2'd0;
            state_d = ST_UNLOAD;
          end else begin
            stage_d = stage_q + 2'd1;
          end
        end else begin
          pair_d = pair_q + 2'd1;
        end
      end
      ST_UNLOAD: begin
        if (out_ready) begin
          ul_idx_d = ul_idx_q + 3'd1;
          if (ul_idx_q == 3'd7) state_d = ST_LOAD;
          else                  state_d = ST_UNLOAD;
        end else begin
          ul_idx_d = ul_idx_q;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_LOAD;
      ld_idx_q <= 3'd0;
      ul_idx_q <= 3'd0;
      stage_q  <= 2'd0;
      pair_q   <= 2'd0;
      s_q      <= 2'd0;
    end else begin
      state_q  <= state_d;
      ld_idx_q <= ld_idx_d;
      ul_idx_q <= ul_idx_d;
      stage_q  <= stage_d;
      pair_q   <= pair_d;
      s_q      <= s_d;
    end
  end

  // Sample buffer: loaded from input, updated in place by the butterfly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NPTS; i++) buf_q[i] <= {DATA_W{1'b0}};
    end else if (ld_we_s) begin
      buf_q[ld_idx_q] <= in_data;
    end else if (bf_we_s) begin
      buf_q[lo_idx_s] <= ao_s;
      buf_q[hi_idx_s] <= bo_s;
    end
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_UNLOAD);
  assign out_data  = out_valid ? buf_q[ul_idx_q] : {DATA_W{1'b0}};
  assign out_last  = out_valid && (ul_idx_q == 3'd7);
  assign busy      = !((state_q == ST_LOAD) && (ld_idx_q == 3'd0));

endmodule

// File: tb/tb_butterfly_seq.sv
// Directed bench for butterfly_seq: hand-computed blocks, latency, backpressure
// and mid-block reset recovery.
module tb_butterfly_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [14:0] in_data = 15'd0;
  logic [1:0]  cfg_stages = 2'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [14:0] out_data;
  logic        out_last;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  logic [14:0] vin  [8];
  logic [14:0] vexp [8];

  always #5 clk = ~clk;

  butterfly_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .cfg_stages (cfg_stages),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feeds vin as one block; cfg_stages is scrambled after beat 0 to prove it is held.
  task automatic load_block(input logic [1:0] s);
    for (int i = 0; i < 8; i++) begin
      in_valid   = 1'b1;
      in_data    = vin[i];
      cfg_stages = (i == 0) ? s : ~s;
      check_val("in_ready_load", {31'd0, in_ready}, 32'd1);
      tick();
      if (i == 0) check_val("busy_load", {31'd0, busy}, 32'd1);
    end
    in_valid   = 1'b0;
    in_data    = 15'h1555;
    cfg_stages = 2'd0;
  endtask

  task automatic wait_valid(input int exp_lat);
    int lat;
    lat = 0;
    while (!out_valid && lat < 40) begin
      check_val("in_ready_compute", {31'd0, in_ready}, 32'd0);
      check_val("busy_compute", {31'd0, busy}, 32'd1);
      tick();
      lat++;
    end
    check_val("latency", lat, exp_lat);
  endtask

  task automatic unload(input bit rand_rdy);
    int n;
    int cyc;
    n = 0;
    cyc = 0;
    while (n < 8 && cyc < 200) begin
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      check_val("out_valid", {31'd0, out_valid}, 32'd1);
      check_val("out_data", {17'd0, out_data}, {17'd0, vexp[n]});
      check_val("out_last", {31'd0, out_last}, {31'd0, (n == 7)});
      if (out_ready) n++;
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    check_val("beats", n, 8);
    check_val("in_ready_after", {31'd0, in_ready}, 32'd1);
    check_val("busy_after", {31'd0, busy}, 32'd0);
    check_val("out_valid_after", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check_val({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check_val({tag, "_out_data"}, {17'd0, out_data}, 32'd0);
    check_val({tag, "_out_last"}, {31'd0, out_last}, 32'd0);
    check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // S=1, ramp 1..8
    vin  = '{15'd1, 15'd2, 15'd3, 15'd4, 15'd5, 15'd6, 15'd7, 15'd8};
    vexp = '{15'd6, 15'd8, 15'd10, 15'd12, 15'h7FC0, 15'h7FC0, 15'h7FC0, 15'h7FC0};
    load_block(2'd1);
    wait_valid(4);
    unload(1'b0);

    // S=0 passes samples straight through
    vexp = '{15'd1, 15'd2, 15'd3, 15'd4, 15'd5, 15'd6, 15'd7, 15'd8};
    load_block(2'd0);
    wait_valid(0);
    unload(1'b0);

    // S=3, all ones
    vin  = '{15'd1, 15'd1, 15'd1, 15'd1, 15'd1, 15'd1, 15'd1, 15'd1};
    vexp = '{15'd8, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0, 15'd0};
    load_block(2'd3);
    wait_valid(12);
    unload(1'b0);

    // S=1 wrap-around: 16383 + -16384 = -1, (16383 - -16384) << 4 wraps to -16
    vin  = '{15'h3FFF, 15'd0, 15'd0, 15'd0, 15'h4000, 15'd0, 15'd0, 15'd0};
    vexp = '{15'h7FFF, 15'd0, 15'd0, 15'd0, 15'h7FF0, 15'd0, 15'd0, 15'd0};
    load_block(2'd1);
    wait_valid(4);
    unload(1'b0);

    // S=2 ramp with random backpressure
    vin  = '{15'd1, 15'd2, 15'd3, 15'd4, 15'd5, 15'd6, 15'd7, 15'd8};
    vexp = '{15'd16, 15'd20, 15'h7FC0, 15'h7FC0, 15'h7F80, 15'h7F80, 15'd0, 15'd0};
    load_block(2'd2);
    wait_valid(8);
    unload(1'b1);

    // Reset in the middle of a compute phase
    vin = '{15'd1, 15'd1, 15'd1, 15'd1, 15'd1, 15'd1, 15'd1, 15'd1};
    load_block(2'd3);
    tick();
    tick();
    tick();
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("no_stale_valid", {31'd0, out_valid}, 32'd0);
    end
    vin  = '{15'd1, 15'd2, 15'd3, 15'd4, 15'd5, 15'd6, 15'd7, 15'd8};
    vexp = '{15'd6, 15'd8, 15'd10, 15'd12, 15'h7FC0, 15'h7FC0, 15'h7FC0, 15'h7FC0};
    load_block(2'd1);
    wait_valid(4);
    unload(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/butterfly_seq.md
BUTTERFLY_SEQ -- requirements
Module: butterfly_seq

Interface
REQ-001 Parameter: DATA_W, 15, sample width; fixed and equal to the butterfly2 operand width.
REQ-002 Parameter: NPTS, 8, points per block; fixed.
REQ-003 Port: clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 Port: rst_n  in  1  reset; asynchronous, active-low.
REQ-005 Port: in_valid  in  1  input sample valid.
REQ-006 Port: in_ready  out  1  block accepts a sample.
REQ-007 Port: in_data  in  15  signed input sample.
REQ-008 Port: cfg_stages  in  2  number of butterfly stages S (0..3) for the block.
REQ-009 Port: out_valid  out  1  output sample valid.
REQ-010 Port: out_ready  in  1  downstream accepts a sample.
REQ-011 Port: out_data  out  15  signed output sample.
REQ-012 Port: out_last  out  1  marks the 8th output sample of a block.
REQ-013 Port: busy  out  1  high whenever a block is in progress.

Function
REQ-014 The block SHALL hold an 8 x 15-bit buffer and run a three-state FSM: LOAD, COMPUTE, UNLOAD.
REQ-015 LOAD: in_ready SHALL be 1; each in_valid&&in_ready beat SHALL write in_data to buf[ld_idx] and increment ld_idx.
REQ-016 cfg_stages SHALL be captured on the first beat of a block (ld_idx=0) and held for that block.
REQ-017 On the 8th beat: the FSM SHALL go to COMPUTE if S>0, else to UNLOAD.
REQ-018 COMPUTE: in_ready SHALL be 0; exactly one butterfly SHALL execute per cycle through a single butterfly2 instance, for 4*S cycles.
REQ-019 Pairing for stage s (0..S-1), pair k (0..3), span h=4>>s: lo=(k/h)*2h+(k mod h), hi=lo+h; buf[lo]<=ao and buf[hi]<=bo at the same edge.
REQ-020 Arithmetic SHALL be modulo 2^15: ao=lo+hi, bo=(lo-hi)<<4, both truncated to 15 bits with no saturation.
REQ-021 Taking the 8th input-accept edge as edge 0, butterfly writes SHALL occur on edges 1..4S; the state SHALL be UNLOAD after edge 4S (after edge 0 when S=0).
REQ-022 UNLOAD: out_valid SHALL be 1, out_data=buf[ul_idx], and out_last=(ul_idx==7).
REQ-023 UNLOAD: ul_idx SHALL advance only on out_valid&&out_ready; out_data and out_last SHALL remain stable while out_ready=0.
REQ-024 After the beat with out_last: the FSM SHALL return to LOAD with ld_idx=0; the next cycle SHALL accept new input (no overlap of load and unload).
REQ-025 busy SHALL be 1 unless (state==LOAD and ld_idx==0).
REQ-026 out_valid SHALL be 0 in LOAD and COMPUTE; in_valid SHALL be ignored outside LOAD.

Reset
REQ-027 While rst_n=0 (asynchronous): state=LOAD; ld_idx, ul_idx, stage and pair counters=0; buffer=0; captured S=0.
REQ-028 Reset output values: in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0.
REQ-029 Reset asserted mid-block SHALL abandon the block; no partial output SHALL appear after reset release.

Structure
REQ-030 Shared package butterfly_pkg SHALL hold DATA_W, NPTS, the state encoding (LOAD/COMPUTE/UNLOAD), and the lo/hi index function.
REQ-031 The only sub-module SHALL be one butterfly2 instance; operand muxing, write-back and counters SHALL live in butterfly_seq.

Verification
REQ-032 S=1, inputs 1..8, out_ready=1 -> outputs 6,8,10,12,-64,-64,-64,-64; out_valid rises 4 cycles after the last accept; out_last only on the 8th output.
REQ-033 S=0, inputs 1..8 -> identical 1..8 in order; out_valid high the cycle after the last accept.
REQ-034 S=3, all inputs 1 -> outputs 8,0,0,0,0,0,0,0; out_valid rises 12 cycles after the last accept; in_ready=0 throughout.
REQ-035 S=1, x0=16383, x4=-16384, others 0 -> out[0]=-1, out[4]=-16 (wrap); others 0.
REQ-036 Backpressure: out_ready random 50% -> out_data/out_last stable while stalled; all 8 samples delivered exactly once, in order.
REQ-037 Reset: rst_n pulsed low during COMPUTE -> outputs at reset values immediately; the next full block yields correct results with no stale data.
